// File: rtl/rand_draw_ctrl_pkg.sv
// Shared definitions for the random-digit draw controller and related
// shared-resource blocks.
package rand_pkg;
   localparam int LFSR_W        = 4;
   localparam int DEF_MAX_DIGIT = 9;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SPIN    = 2'd1,
      CAPTURE = 2'd2,
      DELIVER = 2'd3
   } draw_state_t;
endpackage

// File: rtl/rand_draw_ctrl_if.sv
// Requester/generator bus of the draw controller. The master side owns the
// request lines and the generator value; the slave side is the controller.
interface rand_draw_ctrl_if #(parameter int NUM_REQ = 4);
   import rand_pkg::*;

   logic [NUM_REQ-1:0] req;
   logic [NUM_REQ-1:0] ack;
   logic [LFSR_W-1:0]  digit;
   logic               busy;
   logic               lfsr_stop;
   logic [LFSR_W-1:0]  lfsr_num;

   modport master (output req, lfsr_num, input ack, digit, busy, lfsr_stop);
   modport slave  (input req, lfsr_num, output ack, digit, busy, lfsr_stop);
endinterface

// File: rtl/rand_draw_ctrl_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr,
// searching circularly. Reusable by any shared-resource sequencer.
module rr_arbiter #(
   parameter  int N  = 4,
   localparam int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] idx
);
   logic [IW-1:0] c;
   logic          hit;

   always_comb begin
      gnt = '0;
      idx = '0;
      hit = 1'b0;
      c   = '0;
      for (int k = 0; k < N; k++) begin
         c = IW'((int'(ptr) + k) % N);
         if (!hit && req[c]) begin
            hit    = 1'b1;
            gnt[c] = 1'b1;
            idx    = c;
         end
      end
   end
endmodule

// File: rtl/rand_draw_ctrl.sv
// Shares one free-running 4-bit LFSR between NUM_REQ requesters: spins it for
// a fixed window, rejects out-of-range captures, and returns the digit with a one-cycle ack.
module rand_draw_ctrl
   import rand_pkg::*;
#(
   parameter int NUM_REQ     = 4,
   parameter int SPIN_CYCLES = 4,
   parameter int MAX_DIGIT   = DEF_MAX_DIGIT
) (
   input logic            clk,
   input logic            reset,
   rand_draw_ctrl_if.slave bus
);
   localparam int                IW      = $clog2(NUM_REQ);
   localparam logic [7:0]        SPIN_LD = 8'(SPIN_CYCLES);
   localparam logic [LFSR_W-1:0] MAX_V   = LFSR_W'(MAX_DIGIT);

   draw_state_t        state;
   logic [7:0]         cnt;
   logic [IW-1:0]      ptr;
   logic [IW-1:0]      grant;
   logic [NUM_REQ-1:0] arb_gnt;
   logic [IW-1:0]      arb_idx;
   logic               req_held;

   rr_arbiter #(.N(NUM_REQ)) u_arb (
      .req (bus.req),
      .ptr (ptr),
      .gnt (arb_gnt),
      .idx (arb_idx)
   );

   assign req_held = bus.req[grant];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         cnt           <= '0;
         ptr           <= '0;
         grant         <= '0;
         bus.ack       <= '0;
         bus.digit     <= '0;
         bus.busy      <= 1'b0;
         bus.lfsr_stop <= 1'b1;
      end else begin
         bus.ack <= '0;
         case (state)
            IDLE: begin
               if (|arb_gnt) begin
                  grant         <= arb_idx;
                  cnt           <= SPIN_LD;
                  state         <= SPIN;
                  bus.lfsr_stop <= 1'b0;
                  bus.busy      <= 1'b1;
               end
            end
            SPIN: begin
               if (!req_held) begin
                  state         <= IDLE;
                  cnt           <= '0;
                  bus.lfsr_stop <= 1'b1;
                  bus.busy      <= 1'b0;
               end else begin
                  cnt <= cnt - 8'd1;
                  // Stop lands on the same edge as the last advance, so the
                  // generator moves exactly SPIN_CYCLES times per window.
                  if (cnt == 8'd1) begin
                     state         <= CAPTURE;
                     bus.lfsr_stop <= 1'b1;
                  end
               end
            end
            CAPTURE: begin
               if (!req_held) begin
                  state    <= IDLE;
                  cnt      <= '0;
                  bus.busy <= 1'b0;
               end else if (bus.lfsr_num <= MAX_V) begin
                  bus.digit      <= bus.lfsr_num;
                  bus.ack[grant] <= 1'b1;
                  state          <= DELIVER;
               end else begin
                  cnt           <= SPIN_LD;
                  bus.lfsr_stop <= 1'b0;
                  state         <= SPIN;
               end
            end
            DELIVER: begin
               state    <= IDLE;
               bus.busy <= 1'b0;
               ptr      <= (grant == IW'(NUM_REQ - 1)) ? '0 : grant + IW'(1);
            end
            default: state <= IDLE;
         endcase
      end
   end

   // A zero limit can never be met by a never-zero LFSR.
   a_max_digit: assert property (@(posedge clk) MAX_DIGIT != 0)
      else $error("rand_draw_ctrl: MAX_DIGIT must be >= 1");

   a_ack_onehot: assert property (@(posedge clk) disable iff (reset)
      $onehot0(bus.ack) && (bus.ack == '0 || state == DELIVER))
      else $error("rand_draw_ctrl: ack not one-hot or outside DELIVER");
endmodule

// File: tb/tb_rand_draw_ctrl.sv
// Bench for rand_draw_ctrl: two instances, each driving its own LFSR stub,
// checked against a draw-level reference model.
module tb_rand_draw_ctrl;
   import rand_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic gen_rst = 1'b1;
   always #5 clk = ~clk;

   rand_draw_ctrl_if #(.NUM_REQ(4)) b0 ();
   rand_draw_ctrl_if #(.NUM_REQ(4)) b1 ();

   rand_draw_ctrl #(.NUM_REQ(4), .SPIN_CYCLES(4), .MAX_DIGIT(9)) u0 (
      .clk(clk), .reset(rst), .bus(b0));
   rand_draw_ctrl #(.NUM_REQ(4), .SPIN_CYCLES(2), .MAX_DIGIT(5)) u1 (
      .clk(clk), .reset(rst), .bus(b1));

   // x^4 + x^3 + 1 generator, seed 1111, advances on each edge while not stopped
   function automatic logic [3:0] nxt(input logic [3:0] v);
      return {v[2:0], v[3] ^ v[2]};
   endfunction

   logic [3:0] g0, g1;
   always_ff @(posedge clk) begin
      if (gen_rst) begin
         g0 <= 4'hF;
         g1 <= 4'hF;
      end else begin
         if (!b0.lfsr_stop) g0 <= nxt(g0);
         if (!b1.lfsr_stop) g1 <= nxt(g1);
      end
   end
   assign b0.lfsr_num = g0;
   assign b1.lfsr_num = g1;

   int errors = 0;
   int checks = 0;

   // Reference model state: generator value, RR pointer, last delivered digit
   logic [3:0] m0, m1, last_d0;
   int         mptr0;

   // Spin from g in windows of `spin` advances until a value <= mx appears.
   task automatic predict(input logic [3:0] g, input int spin, input int mx,
                          output logic [3:0] d, output int rej, output logic [3:0] g_after);
      rej = 0;
      for (int w = 0; w < 32; w++) begin
         for (int i = 0; i < spin; i++) g = nxt(g);
         if (int'(g) <= mx) break;
         rej++;
      end
      d = g;
      g_after = g;
   endtask

   function automatic int rr_pick(input logic [3:0] mask, input int ptr);
      for (int k = 0; k < 4; k++)
         if (mask[(ptr + k) % 4]) return (ptr + k) % 4;
      return -1;
   endfunction

   // Counts falling edges until a nonzero ack is seen (bounded).
   task automatic wait_ack(input int which, output logic [3:0] a, output int n);
      n = 0;
      a = '0;
      while (a == 4'd0 && n < 300) begin
         @(negedge clk);
         n++;
         a = (which == 0) ? b0.ack : b1.ack;
      end
   endtask

   task automatic test_reset();
      b0.req = '0;
      b1.req = '0;
      #1 rst = 1'b1;
      #1;
      checks++; if (b0.ack !== 4'd0) begin errors++; $display("FAIL reset_ack: got %b want 0000", b0.ack); end
      checks++; if (b0.digit !== 4'd0) begin errors++; $display("FAIL reset_digit: got %0d want 0", b0.digit); end
      checks++; if (b0.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", b0.busy); end
      checks++; if (b0.lfsr_stop !== 1'b1) begin errors++; $display("FAIL reset_stop: got %b want 1", b0.lfsr_stop); end
      checks++; if (b1.lfsr_stop !== 1'b1) begin errors++; $display("FAIL reset_stop1: got %b want 1", b1.lfsr_stop); end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      gen_rst = 1'b0;
      m0 = 4'hF; m1 = 4'hF; mptr0 = 0; last_d0 = 4'd0;
   endtask

   // Ack falls in cycle SPIN+3 counting the cycle req rises in; req is raised
   // at a falling edge, so that is SPIN+2 falling edges later.
   task automatic test_single_draw();
      logic [3:0] a, d, ga; int n, rej;
      @(negedge clk);
      b0.req = 4'b0001;
      wait_ack(0, a, n);
      checks++; if (a !== 4'b0001) begin errors++; $display("FAIL single_ack: got %b want 0001", a); end
      checks++; if (n !== 6) begin errors++; $display("FAIL single_latency: got %0d want 6", n); end
      checks++; if (b0.digit !== 4'd1) begin errors++; $display("FAIL single_digit: got %0d want 1", b0.digit); end
      b0.req = '0;
      predict(m0, 4, 9, d, rej, ga);
      m0 = ga; mptr0 = 1; last_d0 = d;
      @(negedge clk);
      checks++; if (b0.ack !== 4'd0 || b0.busy !== 1'b0) begin errors++; $display("FAIL single_after: ack %b busy %b want 0000 0", b0.ack, b0.busy); end
   endtask

   task automatic test_second_draw();
      logic [3:0] a, d, ga; int n, rej;
      b0.req = 4'b0001;
      wait_ack(0, a, n);
      checks++; if (a !== 4'b0001) begin errors++; $display("FAIL second_ack: got %b want 0001", a); end
      checks++; if (n !== 6) begin errors++; $display("FAIL second_latency: got %0d want 6", n); end
      checks++; if (b0.digit !== 4'd3) begin errors++; $display("FAIL second_digit: got %0d want 3", b0.digit); end
      b0.req = '0;
      predict(m0, 4, 9, d, rej, ga);
      m0 = ga; mptr0 = 1; last_d0 = d;
      @(negedge clk);
   endtask

   // MAX=5, SPIN=2: 12 rejected, then 1; ack in cycle 8 -> 7 falling edges
   task automatic test_reject();
      logic [3:0] a; int n;
      b1.req = 4'b0001;
      wait_ack(1, a, n);
      checks++; if (a !== 4'b0001) begin errors++; $display("FAIL reject_ack: got %b want 0001", a); end
      checks++; if (n !== 7) begin errors++; $display("FAIL reject_latency: got %0d want 7", n); end
      checks++; if (b1.digit !== 4'd1) begin errors++; $display("FAIL reject_digit: got %0d want 1", b1.digit); end
      b1.req = '0;
      @(negedge clk);
   endtask

   task automatic test_round_robin();
      logic [3:0] a, d, ga; int n, rej, ge;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      mptr0 = 0; last_d0 = 4'd0;
      b0.req = 4'hF;
      for (int k = 0; k < 5; k++) begin
         ge = k % 4;
         predict(m0, 4, 9, d, rej, ga);
         wait_ack(0, a, n);
         checks++; if (a !== 4'(1 << ge)) begin errors++; $display("FAIL rr_order_%0d: got %b want %b", k, a, 4'(1 << ge)); end
         checks++; if (n !== 6 + rej * 5) begin errors++; $display("FAIL rr_latency_%0d: got %0d want %0d", k, n, 6 + rej * 5); end
         checks++; if (b0.digit !== d) begin errors++; $display("FAIL rr_digit_%0d: got %0d want %0d", k, b0.digit, d); end
         m0 = ga; mptr0 = (ge + 1) % 4; last_d0 = d;
         b0.req[ge] = 1'b0;
         @(negedge clk);
         b0.req[ge] = 1'b1;
      end
      b0.req = '0;
      @(negedge clk);
   endtask

   task automatic test_abort();
      logic [3:0] a, d, ga; int n, rej, ge;
      b0.req = 4'b0100;
      @(negedge clk);
      checks++; if (b0.busy !== 1'b1 || b0.lfsr_stop !== 1'b0) begin errors++; $display("FAIL abort_spin: busy %b stop %b want 1 0", b0.busy, b0.lfsr_stop); end
      @(negedge clk);
      b0.req = '0;
      @(negedge clk);
      m0 = nxt(nxt(m0));
      checks++; if (b0.lfsr_stop !== 1'b1) begin errors++; $display("FAIL abort_stop: got %b want 1", b0.lfsr_stop); end
      checks++; if (b0.busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", b0.busy); end
      checks++; if (b0.ack !== 4'd0) begin errors++; $display("FAIL abort_ack: got %b want 0000", b0.ack); end
      checks++; if (b0.digit !== last_d0) begin errors++; $display("FAIL abort_digit: got %0d want %0d", b0.digit, last_d0); end
      // An unchanged pointer picks requester 1 here; a pointer bumped past 2 would pick 3.
      b0.req = 4'b1110;
      ge = rr_pick(4'b1110, mptr0);
      predict(m0, 4, 9, d, rej, ga);
      wait_ack(0, a, n);
      checks++; if (a !== 4'(1 << ge)) begin errors++; $display("FAIL abort_ptr: got %b want %b", a, 4'(1 << ge)); end
      checks++; if (b0.digit !== d) begin errors++; $display("FAIL abort_next_digit: got %0d want %0d", b0.digit, d); end
      m0 = ga; mptr0 = (ge + 1) % 4; last_d0 = d;
      b0.req = '0;
      @(negedge clk);
   endtask

   task automatic test_reset_mid_spin();
      logic [3:0] a, d, ga; int n, rej;
      b0.req = 4'b0001;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      m0 = nxt(m0);
      checks++; if (b0.lfsr_stop !== 1'b1) begin errors++; $display("FAIL midrst_stop: got %b want 1", b0.lfsr_stop); end
      checks++; if (b0.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", b0.busy); end
      checks++; if (b0.digit !== 4'd0) begin errors++; $display("FAIL midrst_digit: got %0d want 0", b0.digit); end
      checks++; if (b0.ack !== 4'd0) begin errors++; $display("FAIL midrst_ack: got %b want 0000", b0.ack); end
      b0.req = '0;
      @(negedge clk);
      rst = 1'b0;
      mptr0 = 0;
      b0.req = 4'b0001;
      predict(m0, 4, 9, d, rej, ga);
      wait_ack(0, a, n);
      checks++; if (a !== 4'b0001) begin errors++; $display("FAIL midrst_next_ack: got %b want 0001", a); end
      checks++; if (n !== 6 + rej * 5) begin errors++; $display("FAIL midrst_next_latency: got %0d want %0d", n, 6 + rej * 5); end
      checks++; if (b0.digit !== d) begin errors++; $display("FAIL midrst_next_digit: got %0d want %0d", b0.digit, d); end
      m0 = ga; mptr0 = 1; last_d0 = d;
      b0.req = '0;
      @(negedge clk);
   endtask

   // Random request sets; new arrivals join while a draw is in flight.
   task automatic test_random();
      logic [3:0] a, d, ga, pending; int n, rej, ge, base;
      pending = 4'($urandom_range(1, 15));
      b0.req = pending;
      base = 6;
      for (int it = 0; it < 24; it++) begin
         ge = rr_pick(pending, mptr0);
         predict(m0, 4, 9, d, rej, ga);
         wait_ack(0, a, n);
         checks++; if (a !== 4'(1 << ge)) begin errors++; $display("FAIL rand_grant_%0d: got %b want %b", it, a, 4'(1 << ge)); end
         checks++; if (n !== base + rej * 5) begin errors++; $display("FAIL rand_latency_%0d: got %0d want %0d", it, n, base + rej * 5); end
         checks++; if (b0.digit !== d) begin errors++; $display("FAIL rand_digit_%0d: got %0d want %0d", it, b0.digit, d); end
         m0 = ga; mptr0 = (ge + 1) % 4;
         pending[ge] = 1'b0;
         pending = pending | (4'($urandom_range(0, 15)) & ~4'(1 << ge));
         b0.req = pending;
         if (pending == 4'd0) begin
            @(negedge clk);
            pending = 4'($urandom_range(1, 15));
            b0.req = pending;
            base = 6;
         end else begin
            base = 7;
         end
      end
      b0.req = '0;
      repeat (40) @(negedge clk);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single_draw();
      test_second_draw();
      test_reject();
      test_round_robin();
      test_abort();
      test_reset_mid_spin();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
